// File: rtl/leaf_inject_scheduler_pkg.sv
// Shared BFT definitions: switch direction codes, injection throttle states
// and packet field layout helpers ({valid, dest_addr, payload}, valid as MSB).
package leaf_inject_scheduler_pkg;

    typedef enum logic [1:0] {
        DIR_LEFT  = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_UP    = 2'd2,
        DIR_VOID  = 2'd3
    } bft_dir_e;

    typedef enum logic {
        RUN  = 1'b0,
        IDLE = 1'b1
    } throttle_state_e;

    localparam int unsigned PKT_PAYLOAD_LSB = 0;
    localparam int unsigned RX_FIFO_DEPTH   = 4;

    function automatic int unsigned pkt_addr_lsb(input int unsigned payload_w);
        return payload_w;
    endfunction

    function automatic int unsigned pkt_valid_bit(input int unsigned addr_w,
                                                  input int unsigned payload_w);
        return addr_w + payload_w;
    endfunction

endpackage

// File: rtl/leaf_inject_scheduler_rr_arbiter.sv
// Round-robin arbiter: scans req starting at ptr, wrapping modulo N, and
// grants the first requester as a one-hot vector.
module rr_arbiter
    import leaf_inject_scheduler_pkg::*;
#(
    parameter  int unsigned N  = 4,
    localparam int unsigned PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant
);

    logic [PW-1:0] idx;
    logic          found;

    // N is a power of two, so the PW-bit add wraps the search index for free
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = ptr + PW'(k);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/leaf_inject_scheduler.sv
// Leaf injection scheduler: round-robin shares one leaf injection port among
// local sources with a burst throttle, and buffers delivered packets in a FIFO.
module leaf_inject_scheduler
    import leaf_inject_scheduler_pkg::*;
#(
    parameter int unsigned num_srcs   = 4,
    parameter int unsigned num_leaves = 256,
    parameter int unsigned payload_sz = 43,
    parameter int unsigned p_sz       = 52,
    parameter int unsigned burst_max  = 8
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic [num_srcs-1:0]                    src_valid,
    output logic [num_srcs-1:0]                    src_ready,
    input  logic [num_srcs*$clog2(num_leaves)-1:0] src_dest,
    input  logic [num_srcs*payload_sz-1:0]         src_payload,
    output logic [p_sz-1:0]                        bus_o,
    input  logic [p_sz-1:0]                        bus_i,
    output logic                                   rx_valid,
    input  logic                                   rx_ready,
    output logic [payload_sz-1:0]                  rx_data,
    output logic [15:0]                            rx_drop_cnt
);

    localparam int unsigned A         = $clog2(num_leaves);
    localparam int unsigned SW        = $clog2(num_srcs);
    localparam int unsigned BW        = $clog2(burst_max + 1);
    localparam int unsigned ADDR_LSB  = pkt_addr_lsb(payload_sz);
    localparam int unsigned VALID_BIT = pkt_valid_bit(A, payload_sz);

    throttle_state_e       state_q;
    logic [BW-1:0]         burst_cnt_q;
    logic [SW-1:0]         rr_ptr_q, rr_ptr_d, gnt_idx;
    logic [num_srcs-1:0]   arb_req, grant;
    logic                  gnt_any;
    logic [A-1:0]          gnt_dest;
    logic [payload_sz-1:0] gnt_payload;
    logic [p_sz-1:0]       bus_d;

    // Reset and the idle cycle both gate requests, so no grant can leak out
    assign arb_req = (reset_n && state_q == RUN) ? src_valid : '0;

    rr_arbiter #(.N(num_srcs)) u_arb (
        .req   (arb_req),
        .ptr   (rr_ptr_q),
        .grant (grant)
    );

    assign src_ready = grant;
    assign gnt_any   = |grant;

    always_comb begin
        gnt_idx     = '0;
        gnt_dest    = '0;
        gnt_payload = '0;
        for (int unsigned i = 0; i < num_srcs; i++) begin
            if (grant[i]) begin
                gnt_idx     = SW'(i);
                gnt_dest    = src_dest[i*A +: A];
                gnt_payload = src_payload[i*payload_sz +: payload_sz];
            end
        end
    end

    assign rr_ptr_d = gnt_any ? gnt_idx + SW'(1) : rr_ptr_q;

    always_comb begin
        bus_d = '0;
        if (gnt_any) begin
            bus_d[VALID_BIT]                        = 1'b1;
            bus_d[ADDR_LSB +: A]                    = gnt_dest;
            bus_d[PKT_PAYLOAD_LSB +: payload_sz]    = gnt_payload;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus_o    <= '0;
            rr_ptr_q <= '0;
        end else begin
            bus_o    <= bus_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= RUN;
            burst_cnt_q <= '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (!gnt_any) begin
                        burst_cnt_q <= '0;
                    end else if (burst_cnt_q == BW'(burst_max - 1)) begin
                        state_q     <= IDLE;
                        burst_cnt_q <= '0;
                    end else begin
                        burst_cnt_q <= burst_cnt_q + BW'(1);
                    end
                end
                IDLE: begin
                    state_q     <= RUN;
                    burst_cnt_q <= '0;
                end
                default: begin
                    state_q     <= RUN;
                    burst_cnt_q <= '0;
                end
            endcase
        end
    end

    logic [payload_sz-1:0] fifo_mem [RX_FIFO_DEPTH];
    logic [1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [2:0]            count_q, count_d, count_after_pop;
    logic                  rx_valid_q;
    logic [15:0]           drop_q, drop_d;
    logic                  push_in, push, pop, drop;
    logic                  unused_bus_dest;

    assign push_in         = bus_i[VALID_BIT];
    assign pop             = rx_valid_q & rx_ready;
    assign unused_bus_dest = ^bus_i[ADDR_LSB +: A];

    // Fullness is judged after this cycle's pop, so push+pop on a full FIFO fits
    always_comb begin
        count_after_pop = count_q - {2'b00, pop};
        push            = push_in && (count_after_pop != 3'(RX_FIFO_DEPTH));
        drop            = push_in && !push;
        wr_ptr_d        = wr_ptr_q + {1'b0, push};
        rd_ptr_d        = rd_ptr_q + {1'b0, pop};
        count_d         = count_after_pop + {2'b00, push};
        drop_d          = (drop && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rx_valid_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rx_valid_q <= (count_d != 3'd0);
            drop_q     <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= bus_i[payload_sz-1:0];
        end
    end

    assign rx_valid    = rx_valid_q;
    assign rx_data     = fifo_mem[rd_ptr_q];
    assign rx_drop_cnt = drop_q;

endmodule
